// File: rtl/bcd_to_bin_seq.sv
// Packed-BCD to binary converter, Horner method one digit per clock, MSD first.
// Result valid NUM_DIGITS cycles after accept; held in DONE until out_ready, one word in flight.
module bcd_to_bin_seq #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_W-1:0]        bin,
  output logic                    err
);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAX_DEC = pow10(NUM_DIGITS) - 1;
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SH_W  = 4 * NUM_DIGITS;

  generate
    if (NUM_DIGITS < 1 || BIN_W < 4 || (BIN_W < 63 && (64'd1 << BIN_W) <= MAX_DEC)) begin : g_bad_width
      $error("bcd_to_bin_seq: BIN_W too narrow for NUM_DIGITS");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [BIN_W-1:0] acc_q,     acc_d;
  logic [SH_W-1:0]  sh_q,      sh_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             err_int_q, err_int_d;
  logic [BIN_W-1:0] bin_q,     bin_d;
  logic             err_q,     err_d;

  logic [3:0]       digit;
  logic [BIN_W-1:0] acc_step;
  logic             err_step;
  logic             last_digit;

  // Non-decimal nibbles still fold into the accumulator; the err flag masks the result later.
  assign digit      = sh_q[SH_W-1 -: 4];
  assign acc_step   = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
  assign err_step   = err_int_q | (digit > 4'd9);
  assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    err_int_d = err_int_q;
    bin_d     = bin_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sh_d      = bcd_in;
          acc_d     = '0;
          cnt_d     = '0;
          err_int_d = 1'b0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        acc_d     = acc_step;
        err_int_d = err_step;
        sh_d      = sh_q << 4;
        cnt_d     = cnt_q + 1'b1;
        if (last_digit) begin
          bin_d   = err_step ? '0 : acc_step;
          err_d   = err_step;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      err_int_q <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      err_int_q <= err_int_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign bin       = bin_q;
  assign err       = err_q;

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential packed-BCD to binary converter. It is the inverse of the team's binary-to-BCD display path.
- Converts a NUM_DIGITS BCD word, such as a value entered digit-by-digit on the keypad/switch front end, into an unsigned binary count for the core logic.
- Uses Horner iteration: one digit per clock, most significant digit first, acc = acc*10 + digit.
- Valid/ready handshake on both sides; one conversion in flight at a time.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in bcd_in.
- BIN_W, 14, binary output width. Must satisfy 2^BIN_W > 10^NUM_DIGITS - 1 (4 digits -> 14 bits, max 9999). Elaboration fails otherwise.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  bcd_in holds a word to convert.
- in_ready  out  1  converter can accept a word.
- bcd_in  in  4*NUM_DIGITS  packed BCD. [3:0] is the ones digit, top nibble is the most significant digit.
- out_valid  out  1  bin/err hold a finished result.
- out_ready  in  1  consumer accepts the result.
- bin  out  BIN_W  binary result.
- err  out  1  at least one input nibble was > 9.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; bin=0; err=0.
  - Internal accumulator, digit shift register and digit counter cleared.
  - Deassertion is sampled synchronously: first legal accept is at the first rising edge with rst_n=1.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture bcd_in into the shift register, acc=0, cnt=0, err_int=0, go to CONV.
  - bin and err keep their previous values until the next result.
- CONV:
  - in_ready=0; in_valid is ignored.
  - Each edge: d = top nibble; acc <= acc*10 + d, computed at BIN_W bits (written as (acc<<3)+(acc<<1)+d).
  - Also each edge: err_int |= (d>9); shift register moves left 4; cnt++.
  - When cnt reaches NUM_DIGITS-1, that edge processes the last digit and moves to DONE.
  - The same edge loads bin and err and sets out_valid=1:
    - bin = final acc, or 0 if the final err_int is set;
    - err = final err_int.
- Latency: for an accept at edge E0, out_valid rises after edge E(NUM_DIGITS). That is 4 cycles for the default.
- DONE:
  - out_valid=1, in_ready=0.
  - bin and err are held stable while out_ready=0, for any duration.
  - On an edge with out_ready=1: out_valid=0, state=IDLE, and in_ready=1 from the next cycle.
  - Throughput: 1 conversion per NUM_DIGITS+2 cycles.
- Arithmetic:
  - Valid input never overflows BIN_W, so no saturation is needed.
  - Nibbles A..F are still folded into acc, and may wrap mod 2^BIN_W. The result is masked to 0 by err.
- Boundaries:
  - in_valid held high through CONV/DONE: the word is not re-captured until back in IDLE. The source keeps in_valid high until it sees in_ready=1.
  - in_valid and out_ready both high in DONE: only the output handshake completes. The input is taken on a later IDLE edge.
  - rst_n low mid-CONV or mid-DONE: outputs return to reset values immediately. The partial result is discarded and never presented.
  - All-zero input: bin=0, err=0, normal latency.

Test Plan:
- Reset, then bcd_in=16'h1234 with in_valid one cycle, out_ready=1 -> out_valid exactly 4 cycles after accept, bin=1234 (0x4D2), err=0; in_ready high again 1 cycle after output handshake.
- bcd_in=16'h9999 and then 16'h0000 back-to-back, in_valid held high -> bin=9999 (0x270F) then bin=0, each err=0; second accept occurs only once in_ready=1.
- bcd_in=16'h12A4 -> err=1, bin=0, same 4-cycle latency; following 16'h0007 -> err=0, bin=7 (err does not stick across conversions).
- 16'h0500 with out_ready held 0 for 10 cycles -> out_valid, bin=500 and err stay stable, in_ready=0 throughout; out_ready=1 -> handshake on that edge, back to IDLE.
- Pulse rst_n low 2 cycles after accepting 16'h4321 -> out_valid, bin, err immediately 0 and in_ready=1; no result for 4321 appears; a subsequent 16'h0042 converts to 42.
